// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the random-asynchronous simulation control path.
package sim_ctrl_pkg;

  localparam int unsigned LfsrW = 16;
  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [LfsrW-1:0] LfsrTaps        = 16'hB400;
  localparam logic [LfsrW-1:0] LfsrSeedDefault = 16'hACE1;

  // Sizing defaults shared with the datapath state registers.
  localparam int unsigned DefRules  = 68;
  localparam int unsigned DefRLog2  = 7;
  localparam int unsigned DefRoundW = 10;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StPick,
    StEval,
    StCommit,
    StRoundEnd,
    StDone
  } state_e;

  // Fibonacci step: shift left, feedback XOR of the tapped bits enters at bit 0.
  function automatic logic [LfsrW-1:0] lfsr_next(input logic [LfsrW-1:0] v);
    return {v[LfsrW-2:0], ^(v & LfsrTaps)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and step-enable.
module lfsr16
  import sim_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LfsrW-1:0] load_val,
  input  logic             advance,
  output logic [LfsrW-1:0] value
);

  logic [LfsrW-1:0] value_q;

  // Load has priority over advance; reset clears to the all-zero (stuck) state.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (advance) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/async_update_sequencer.sv
// Control FSM for the random-asynchronous update datapath: draws rule addresses
// from an LFSR, handshakes evaluation, strobes state-register writes, counts rounds.
module async_update_sequencer
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned      RULES        = DefRules,
  parameter int unsigned      R_LOG_2      = DefRLog2,
  parameter int unsigned      ROUND_W      = DefRoundW,
  parameter logic [LfsrW-1:0] SEED_DEFAULT = LfsrSeedDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LfsrW-1:0]   seed,
  input  logic [ROUND_W-1:0] max_rounds,
  input  logic               eval_ack,
  input  logic               trace_ready,
  output logic               busy,
  output logic               done,
  output logic               eval_req,
  output logic [R_LOG_2-1:0] sel,
  output logic               load,
  output logic [ROUND_W-1:0] round_number,
  output logic               round_done,
  output logic [15:0]        miss_count
);

  // Step counter is one bit wider so it can reach RULES == 2**R_LOG_2.
  localparam logic [R_LOG_2:0]   RulesW   = (R_LOG_2 + 1)'(RULES);
  localparam logic [R_LOG_2:0]   StepOne  = {{R_LOG_2{1'b0}}, 1'b1};
  localparam logic [ROUND_W-1:0] RoundOne = {{(ROUND_W - 1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [R_LOG_2-1:0] sel_q, sel_d;
  logic [R_LOG_2:0]   step_q, step_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [ROUND_W-1:0] max_q, max_d;
  logic [15:0]        miss_q, miss_d;

  logic               lfsr_load, lfsr_advance;
  logic [LfsrW-1:0]   lfsr_value, lfsr_seed;
  logic [R_LOG_2-1:0] candidate;
  logic               cand_valid;
  logic [R_LOG_2:0]   step_plus;
  logic [ROUND_W-1:0] round_plus;
  logic               unused_lfsr_hi;

  // A zero seed would lock the LFSR, so substitute the default.
  assign lfsr_seed = (seed == '0) ? SEED_DEFAULT : seed;

  lfsr16 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (lfsr_seed),
    .advance  (lfsr_advance),
    .value    (lfsr_value)
  );

  assign candidate      = lfsr_value[R_LOG_2-1:0];
  assign unused_lfsr_hi = ^lfsr_value[LfsrW-1:R_LOG_2];
  assign cand_valid     = ({1'b0, candidate} < RulesW);
  assign step_plus      = step_q + StepOne;
  assign round_plus     = round_q + RoundOne;

  // Next-state and datapath-register updates.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    step_d       = step_q;
    round_d      = round_q;
    max_d        = max_q;
    miss_d       = miss_q;
    lfsr_load    = 1'b0;
    lfsr_advance = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StSeed;
          max_d     = max_rounds;
          round_d   = '0;
          step_d    = '0;
          miss_d    = '0;
          lfsr_load = 1'b1;
        end
      end
      StSeed: begin
        state_d = (max_q == '0) ? StDone : StPick;
      end
      StPick: begin
        lfsr_advance = 1'b1;
        if (cand_valid) begin
          sel_d   = candidate;
          state_d = StEval;
        end else if (miss_q != '1) begin
          miss_d = miss_q + 16'd1;
        end
      end
      StEval: begin
        if (eval_ack) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        if (step_plus == RulesW) begin
          step_d  = '0;
          state_d = StRoundEnd;
        end else begin
          step_d  = step_plus;
          state_d = StPick;
        end
      end
      StRoundEnd: begin
        if (trace_ready) begin
          round_d = round_plus;
          state_d = (round_plus == max_q) ? StDone : StPick;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      step_q  <= '0;
      round_q <= '0;
      max_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      round_q <= round_d;
      max_q   <= max_d;
      miss_q  <= miss_d;
    end
  end

  // Handshake and strobe outputs decode directly from the state register.
  assign busy         = (state_q != StIdle) && (state_q != StDone);
  assign done         = (state_q == StDone);
  assign eval_req     = (state_q == StEval);
  assign load         = (state_q == StCommit);
  assign round_done   = (state_q == StRoundEnd);
  assign sel          = sel_q;
  assign round_number = round_q;
  assign miss_count   = miss_q;

endmodule

// File: tb/tb_async_update_sequencer.sv
// Directed self-checking bench: small (RULES=4) and default (RULES=68) instances.
module tb_async_update_sequencer;

  logic        clk;
  logic        rst;
  logic        start_s, start_l;
  logic [15:0] seed;
  logic [9:0]  max_rounds;
  logic        eval_ack, trace_ready;

  logic        busy_s, done_s, eval_req_s, load_s, round_done_s;
  logic [1:0]  sel_s;
  logic [9:0]  round_s;
  logic [15:0] miss_s;

  logic        busy_l, done_l, eval_req_l, load_l, round_done_l;
  logic [6:0]  sel_l;
  logic [9:0]  round_l;
  logic [15:0] miss_l;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] exp_sel_l [68];
  int         exp_miss;
  int         first_miss;

  async_update_sequencer #(
    .RULES   (4),
    .R_LOG_2 (2)
  ) dut_s (
    .clk          (clk),
    .rst          (rst),
    .start        (start_s),
    .seed         (seed),
    .max_rounds   (max_rounds),
    .eval_ack     (eval_ack),
    .trace_ready  (trace_ready),
    .busy         (busy_s),
    .done         (done_s),
    .eval_req     (eval_req_s),
    .sel          (sel_s),
    .load         (load_s),
    .round_number (round_s),
    .round_done   (round_done_s),
    .miss_count   (miss_s)
  );

  async_update_sequencer dut_l (
    .clk          (clk),
    .rst          (rst),
    .start        (start_l),
    .seed         (seed),
    .max_rounds   (max_rounds),
    .eval_ack     (eval_ack),
    .trace_ready  (trace_ready),
    .busy         (busy_l),
    .done         (done_l),
    .eval_req     (eval_req_l),
    .sel          (sel_l),
    .load         (load_l),
    .round_number (round_l),
    .round_done   (round_done_l),
    .miss_count   (miss_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  initial begin
    logic [15:0] m;
    int nv;
    int nloads, nrd, c;
    int load_cyc [4];
    logic [1:0] got_sel [4];
    logic [1:0] small_exp [4];

    // Reference draw sequence for the default instance from 16'hACE1.
    m = 16'hACE1; nv = 0; exp_miss = 0; first_miss = 0;
    while (nv < 68) begin
      if (m[6:0] < 7'd68) begin
        if (nv == 0) first_miss = exp_miss;
        exp_sel_l[nv] = m[6:0];
        nv++;
      end else begin
        exp_miss++;
      end
      m = ref_next(m);
    end
    // seed 1: 0001 -> 0002 -> 0004 -> 0008, low two bits 1,2,0,0.
    small_exp[0] = 2'd1; small_exp[1] = 2'd2; small_exp[2] = 2'd0; small_exp[3] = 2'd0;

    rst = 1'b1; start_s = 1'b0; start_l = 1'b0; seed = '0; max_rounds = '0;
    eval_ack = 1'b0; trace_ready = 1'b0;

    // 1. Reset then idle.
    tick(); tick();
    rst = 1'b0;
    tick();
    check_val("rst_busy", 32'(busy_s), 0);
    check_val("rst_done", 32'(done_s), 0);
    check_val("rst_eval_req", 32'(eval_req_s), 0);
    check_val("rst_sel", 32'(sel_l), 0);
    check_val("rst_round", 32'(round_l), 0);
    check_val("rst_round_done", 32'(round_done_l), 0);
    check_val("rst_miss", 32'(miss_l), 0);
    nloads = 0;
    for (int i = 0; i < 5; i++) begin
      if (load_s || load_l) nloads++;
      tick();
    end
    check_val("idle_no_load", 32'(nloads), 0);

    // 2. Basic round on RULES=4.
    seed = 16'h0001; max_rounds = 10'd1; eval_ack = 1'b1; trace_ready = 1'b1;
    start_s = 1'b1; tick(); start_s = 1'b0;
    nloads = 0; nrd = 0;
    for (c = 0; c < 200 && !done_s; c++) begin
      tick();
      if (load_s) begin
        if (nloads < 4) begin
          load_cyc[nloads] = c;
          got_sel[nloads]  = sel_s;
        end
        nloads++;
      end
      if (round_done_s) nrd++;
    end
    check_val("t2_done", 32'(done_s), 1);
    check_val("t2_loads", 32'(nloads), 4);
    for (int i = 1; i < 4; i++) check_val("t2_spacing", 32'(load_cyc[i] - load_cyc[i-1]), 3);
    for (int i = 0; i < 4; i++) check_val("t2_sel", 32'(got_sel[i]), 32'(small_exp[i]));
    check_val("t2_round_done_cycles", 32'(nrd), 1);
    check_val("t2_round_number", 32'(round_s), 1);
    check_val("t2_busy", 32'(busy_s), 0);

    // 5a. max_rounds = 0 goes straight to DONE via SEED with no loads.
    max_rounds = 10'd0;
    start_s = 1'b1; tick(); start_s = 1'b0;
    check_val("t5_seed_busy", 32'(busy_s), 1);
    check_val("t5_seed_done", 32'(done_s), 0);
    check_val("t5_seed_load", 32'(load_s), 0);
    tick();
    check_val("t5_zero_done", 32'(done_s), 1);
    check_val("t5_zero_busy", 32'(busy_s), 0);
    check_val("t5_zero_load", 32'(load_s), 0);
    check_val("t5_zero_round", 32'(round_s), 0);

    // 4. Handshake stalls, with a start attempt while busy.
    seed = 16'h0001; max_rounds = 10'd1; eval_ack = 1'b0; trace_ready = 1'b0;
    start_s = 1'b1; tick(); start_s = 1'b0;
    for (c = 0; c < 20 && !eval_req_s; c++) tick();
    check_val("t4_eval_seen", 32'(eval_req_s), 1);
    for (int i = 0; i < 5; i++) begin
      check_val("t4_eval_req_hold", 32'(eval_req_s), 1);
      check_val("t4_sel_hold", 32'(sel_s), 1);
      check_val("t4_no_load", 32'(load_s), 0);
      if (i == 1) begin start_s = 1'b1; seed = 16'h0002; end
      if (i == 2) start_s = 1'b0;
      if (i < 4) tick();
    end
    eval_ack = 1'b1;
    tick();
    check_val("t4_commit_load", 32'(load_s), 1);
    check_val("t4_commit_sel", 32'(sel_s), 1);
    tick();
    check_val("t4_single_load", 32'(load_s), 0);
    for (c = 0; c < 20 && !load_s; c++) tick();
    check_val("t4_second_sel", 32'(sel_s), 2);
    for (c = 0; c < 50 && !round_done_s; c++) tick();
    for (int i = 0; i < 7; i++) begin
      check_val("t4_round_done_hold", 32'(round_done_s), 1);
      check_val("t4_round_unchanged", 32'(round_s), 0);
      if (i < 6) tick();
    end
    trace_ready = 1'b1;
    tick();
    check_val("t4_round_done_drop", 32'(round_done_s), 0);
    check_val("t4_round_after", 32'(round_s), 1);
    check_val("t4_done", 32'(done_s), 1);

    // 5b/6. Zero seed uses the default; reset while eval_req is high.
    seed = 16'h0000; max_rounds = 10'd1; eval_ack = 1'b0;
    start_l = 1'b1; tick(); start_l = 1'b0;
    for (c = 0; c < 200 && !eval_req_l; c++) tick();
    check_val("t5_zero_seed_eval", 32'(eval_req_l), 1);
    check_val("t5_zero_seed_sel", 32'(sel_l), 32'(exp_sel_l[0]));
    check_val("t5_zero_seed_miss", 32'(miss_l), 32'(first_miss));
    rst = 1'b1;
    tick();
    check_val("t6_eval_req", 32'(eval_req_l), 0);
    check_val("t6_busy", 32'(busy_l), 0);
    check_val("t6_load", 32'(load_l), 0);
    check_val("t6_sel", 32'(sel_l), 0);
    check_val("t6_miss", 32'(miss_l), 0);
    rst = 1'b0; eval_ack = 1'b1;
    tick();
    check_val("t6_no_load_after", 32'(load_l), 0);

    // 3. Full round on RULES=68 from 16'hACE1, compared to the reference draws.
    seed = 16'hACE1;
    start_l = 1'b1; tick(); start_l = 1'b0;
    nloads = 0;
    for (c = 0; c < 3000 && !done_l; c++) begin
      tick();
      if (load_l) begin
        if (nloads < 68) check_val("t3_sel", 32'(sel_l), 32'(exp_sel_l[nloads]));
        nloads++;
      end
    end
    check_val("t3_done", 32'(done_l), 1);
    check_val("t3_loads", 32'(nloads), 68);
    check_val("t3_miss", 32'(miss_l), 32'(exp_miss));
    check_val("t3_round", 32'(round_l), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
